// File: rtl/mdr_mem_if.sv
// Memory data register for the Mini-SRC datapath, with a req/ack memory handshake,
// sub-word lane handling, a misalignment check and an optional ack timeout.
module mdr_mem_if #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  localparam int OFFS_W = $clog2(DATA_W / 8)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_W-1:0]     BusMuxOut,
  input  logic                  MDRin,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [1:0]            size,
  input  logic                  sext,
  input  logic [OFFS_W-1:0]     addr_lo,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic [DATA_W-1:0]     BusMuxIn_MDR,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    FIN     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic [1:0]          size_q, size_d;
  logic                sext_q, sext_d;
  logic [OFFS_W-1:0]   offs_q, offs_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mis_in;

  function automatic logic misaligned(input logic [1:0] sz, input logic [OFFS_W-1:0] off);
    case (sz)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      default: misaligned = (off != '0);
    endcase
  endfunction

  function automatic logic [BE_W-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = BE_W'(1);
      2'b01:   size_mask = BE_W'(3);
      default: size_mask = '1;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] write_lane(input logic [DATA_W-1:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   write_lane = {{(DATA_W-8){1'b0}}, d[7:0]};
      2'b01:   write_lane = {{(DATA_W-16){1'b0}}, d[15:0]};
      default: write_lane = d;
    endcase
  endfunction

  // The addressed lane is shifted down to bit 0 before extension.
  function automatic logic [DATA_W-1:0] read_lane(input logic [DATA_W-1:0] d, input logic [1:0] sz,
                                                  input logic sx, input logic [OFFS_W-1:0] off);
    logic [DATA_W-1:0] s;
    s = d >> {off, 3'b000};
    case (sz)
      2'b00:   read_lane = {{(DATA_W-8){sx & s[7]}}, s[7:0]};
      2'b01:   read_lane = {{(DATA_W-16){sx & s[15]}}, s[15:0]};
      default: read_lane = s;
    endcase
  endfunction

  assign mis_in = misaligned(size, addr_lo);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    size_d  = size_q;
    sext_d  = sext_q;
    offs_d  = offs_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (Read || Write) begin
          size_d  = size;
          sext_d  = sext;
          offs_d  = addr_lo;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = Read ? RD_WAIT : WR_WAIT;
          if (!mis_in) begin
            req_d   = 1'b1;
            we_d    = !Read;
            be_d    = size_mask(size) << addr_lo;
            wdata_d = Read ? '0 : (write_lane(q_q, size) << {addr_lo, 3'b000});
          end
        end else if (MDRin) begin
          q_d = BusMuxOut;
        end
      end

      RD_WAIT, WR_WAIT: begin
        // A wait state entered without a request means the access was misaligned.
        if (!req_q) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = FIN;
        end else if (mem_ack) begin
          if (state_q == RD_WAIT) begin
            q_d = read_lane(mem_rdata, size_q, sext_q, offs_q);
          end
          done_d  = 1'b1;
          state_d = FIN;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (state_d == FIN) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = '0;
          wdata_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= IDLE;
      q_q     <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      offs_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      offs_q  <= offs_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_be       = be_q;
  assign mem_wdata    = wdata_q;
  assign BusMuxIn_MDR = q_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: doc/mdr_mem_if.md
# mdr_mem_if

Parametrised memory data register with a built-in memory handshake for the Mini-SRC datapath. It holds the MDR value driven onto the bus. It loads either from the bus, or from memory through a req/ack transaction of variable latency. Reads support byte, halfword and word accesses with lane extraction and sign or zero extension. Writes drive MDR contents to the correct byte lanes with byte enables, and a timeout and misalignment check terminate bad accesses.

## Interface
Parameters:
- DATA_W, 32, data width; multiple of 8, at least 32.
- TIMEOUT, 16, cycles to wait for mem_ack before aborting; 0 disables the timeout.
- OFFS_W (localparam) = log2(DATA_W/8).

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- clear  in  1  reset; synchronous, active-low.
- BusMuxOut  in  DATA_W  bus value for MDRin loads.
- MDRin  in  1  load q from BusMuxOut (IDLE only).
- Read  in  1  start memory read.
- Write  in  1  start memory write of q.
- size  in  2  00 byte, 01 half, 10/11 word.
- sext  in  1  1 = sign-extend sub-word reads, 0 = zero-extend.
- addr_lo  in  OFFS_W  byte offset from MAR.
- mem_req  out  1  transaction request.
- mem_we  out  1  1 = write transaction.
- mem_be  out  DATA_W/8  byte enables.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  transaction complete.
- BusMuxIn_MDR  out  DATA_W  register contents q.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  last command failed; held until the next accepted command.

## Operation
- States: IDLE, RD_WAIT, WR_WAIT, FIN.
- IDLE priority: Read > Write > MDRin. Accepting Read or Write latches size, sext, addr_lo, clears err and enters RD_WAIT/WR_WAIT. MDRin loads q <= BusMuxOut and stays in IDLE with no done pulse.
- Commands and MDRin are ignored outside IDLE.
- Misaligned access: half at odd offset, or word at nonzero offset.
  - No request is issued; err=1; go to FIN.
  - q is unchanged.
- RD_WAIT: mem_req=1, mem_we=0, mem_be = lanes of the access. On mem_ack, load q with the selected lane right-justified and extended per size/sext, then go to FIN.
- WR_WAIT: mem_req=1, mem_we=1.
  - mem_wdata = low byte/half/word of q shifted left by 8*addr_lo.
  - mem_be = size mask shifted left by addr_lo.
  - On mem_ack go to FIN; q is unchanged.
- Timeout: a wait counter resets on entry to RD_WAIT/WR_WAIT. If no ack arrives after TIMEOUT cycles of mem_req, drop the request, set err=1 and go to FIN; q is unchanged.
- FIN: done=1 for one cycle, then IDLE.
- busy=1 in RD_WAIT, WR_WAIT and FIN.
- mem_ack is ignored while mem_req=0.
- While mem_req=0: mem_we=0, mem_be=0, mem_wdata=0.

## Timing
- Reset (clear=0 at an edge): q=0, state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_wdata=0, busy=0, done=0, err=0, counter=0. This applies mid-transaction; a late ack after reset is ignored.
- Read accepted at edge E: mem_req goes high after E.
  - Ack sampled at edge E+k (k≥1) updates q at that edge.
  - done is high between E+k and E+k+1.
  - Minimum command-to-done latency is 2 edges.
- Misaligned command at edge E: done and err are high after E+1; mem_req never rises.
- Timeout: the request is held exactly TIMEOUT cycles; mem_req is low after the abort edge. An ack on that same edge wins (normal completion).
- BusMuxIn_MDR reflects q directly, with no extra delay.

## Test plan
- Reset: preload q=32'hDEADBEEF via MDRin, then clear=0 for one edge -> BusMuxIn_MDR=0, busy=0, err=0.
- Word read, ack after 3 wait cycles, mem_rdata=32'h12345678 -> q=32'h12345678, done one cycle, mem_be=4'b1111.
- Byte read with addr_lo=3 and mem_rdata=32'h80FF0000: sext=1 gives q=32'hFFFFFF80; sext=0 gives q=32'h00000080.
- Half write of q=32'h0000ABCD at addr_lo=2 -> mem_we=1, mem_be=4'b1100, mem_wdata=32'hABCD0000; q is unchanged.
- Word read at addr_lo=1 -> no mem_req, err=1, done; q is unchanged. Separately, a read with no ack and TIMEOUT=16 -> mem_req high for 16 cycles, then err=1 and done.
- Read and Write asserted together, with MDRin asserted while busy -> a read is performed; MDRin is ignored and q equals the read data.
